// File: rtl/trig_route_ctrl_if.sv
// Bus between a trigger consumer/configurator and trig_route_ctrl:
// sources and configuration toward the router, conditioned trigger and status back.
interface trig_route_ctrl_if #(
  parameter int pNUM_SRC    = 4,
  parameter int pSEL_WIDTH  = $clog2(pNUM_SRC),
  parameter int pTIME_WIDTH = 16,
  parameter int pCNT_WIDTH  = 16
);
  logic [pNUM_SRC-1:0]    I_trig_src;
  logic [pSEL_WIDTH-1:0]  I_src_sel;
  logic                   I_mode;
  logic [pTIME_WIDTH-1:0] I_min_width;
  logic [pTIME_WIDTH-1:0] I_holdoff;
  logic                   I_count_clr;
  logic                   O_trig_out;
  logic [pCNT_WIDTH-1:0]  O_event_count;
  logic                   O_dropped;
  logic                   O_busy;
  logic                   O_heartbeat;

  modport master (
    output I_trig_src, I_src_sel, I_mode, I_min_width, I_holdoff, I_count_clr,
    input  O_trig_out, O_event_count, O_dropped, O_busy, O_heartbeat
  );

  modport slave (
    input  I_trig_src, I_src_sel, I_mode, I_min_width, I_holdoff, I_count_clr,
    output O_trig_out, O_event_count, O_dropped, O_busy, O_heartbeat
  );
endinterface

// File: rtl/trig_route_ctrl.sv
// Trigger router/conditioner: source select, level or pulse shaping with holdoff,
// event counter, drop flag, heartbeat. Optional input glitch filter: TRIG_ROUTE_GLITCH_FILTER_EN.
module trig_route_ctrl #(
  parameter int pNUM_SRC    = 4,
  parameter int pSEL_WIDTH  = $clog2(pNUM_SRC),
  parameter int pTIME_WIDTH = 16,
  parameter int pCNT_WIDTH  = 16,
  parameter int pHB_WIDTH   = 23
) (
  input logic              ext_clock,
  input logic              resetn,
  trig_route_ctrl_if.slave bus
);

  localparam logic [pSEL_WIDTH:0]    NUM_SRC_EXT = (pSEL_WIDTH+1)'(pNUM_SRC);
  localparam logic [pTIME_WIDTH-1:0] TIME_ONE    = pTIME_WIDTH'(1);
  localparam logic [pCNT_WIDTH-1:0]  CNT_ONE     = pCNT_WIDTH'(1);
  localparam logic [pHB_WIDTH-1:0]   HB_ONE      = pHB_WIDTH'(1);

  typedef enum logic [1:0] {IDLE, ACTIVE, HOLDOFF} state_t;

  state_t                 state, state_nxt;
  logic                   raw_sel;
  logic                   sel_p0, sel_p1;
  logic                   edge_det;
  logic                   trig, trig_nxt;
  logic [pTIME_WIDTH-1:0] tcnt, tcnt_nxt;
  logic [pTIME_WIDTH-1:0] hold_lat, hold_nxt;
  logic [pTIME_WIDTH-1:0] width_eff;
  logic                   accept, drop;
  logic [pCNT_WIDTH-1:0]  count;
  logic                   dropped;
  logic [pHB_WIDTH-1:0]   hb;

  function automatic logic [pCNT_WIDTH-1:0] sat_inc(input logic [pCNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  // Out-of-range select reads as a constant-low source
  always_comb begin
    raw_sel = 1'b0;
    if ({1'b0, bus.I_src_sel} < NUM_SRC_EXT) raw_sel = bus.I_trig_src[bus.I_src_sel];
  end

  // Stage p0: selected source (optionally debounced over two samples)
`ifdef TRIG_ROUTE_GLITCH_FILTER_EN
  logic raw_p0;
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) begin
      raw_p0 <= 1'b0;
      sel_p0 <= 1'b0;
    end else begin
      raw_p0 <= raw_sel;
      if (raw_p0 && raw_sel)        sel_p0 <= 1'b1;
      else if (!raw_p0 && !raw_sel) sel_p0 <= 1'b0;
    end
  end
`else
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) sel_p0 <= 1'b0;
    else         sel_p0 <= raw_sel;
  end
`endif

  // Stage p1: delayed copy for rising-edge detection
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) sel_p1 <= 1'b0;
    else         sel_p1 <= sel_p0;
  end

  assign edge_det  = sel_p0 & ~sel_p1;
  assign width_eff = (bus.I_min_width == '0) ? TIME_ONE : bus.I_min_width;

  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.I_mode && edge_det) state_nxt = ACTIVE;
      ACTIVE:  if (tcnt == TIME_ONE) state_nxt = (hold_lat != '0) ? HOLDOFF : IDLE;
      HOLDOFF: if (tcnt == TIME_ONE) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Configuration is captured only when a pulse starts; edges outside IDLE are drops
  always_comb begin
    trig_nxt = 1'b0;
    tcnt_nxt = tcnt;
    hold_nxt = hold_lat;
    accept   = 1'b0;
    drop     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.I_mode) begin
          trig_nxt = sel_p0;
          accept   = edge_det;
        end else if (edge_det) begin
          trig_nxt = 1'b1;
          tcnt_nxt = width_eff;
          hold_nxt = bus.I_holdoff;
          accept   = 1'b1;
        end
      end
      ACTIVE: begin
        drop = edge_det;
        if (tcnt == TIME_ONE) begin
          trig_nxt = 1'b0;
          tcnt_nxt = hold_lat;
        end else begin
          trig_nxt = 1'b1;
          tcnt_nxt = tcnt - TIME_ONE;
        end
      end
      HOLDOFF: begin
        drop     = edge_det;
        tcnt_nxt = tcnt - TIME_ONE;
      end
      default: trig_nxt = 1'b0;
    endcase
  end

  // Stage p2: registered trigger, timers, counters
  always_ff @(posedge ext_clock or negedge resetn) begin
    if (!resetn) begin
      trig     <= 1'b0;
      tcnt     <= '0;
      hold_lat <= '0;
      count    <= '0;
      dropped  <= 1'b0;
      hb       <= '0;
    end else begin
      trig     <= trig_nxt;
      tcnt     <= tcnt_nxt;
      hold_lat <= hold_nxt;
      if (bus.I_count_clr) begin
        count   <= '0;
        dropped <= 1'b0;
      end else begin
        if (accept) count   <= sat_inc(count);
        if (drop)   dropped <= 1'b1;
      end
      if (!trig) hb <= hb + HB_ONE;
    end
  end

  assign bus.O_trig_out    = trig;
  assign bus.O_event_count = count;
  assign bus.O_dropped     = dropped;
  assign bus.O_busy        = (state != IDLE);
  assign bus.O_heartbeat   = hb[pHB_WIDTH-1];

endmodule

// File: tb/tb_trig_route_ctrl.sv
// Bench for trig_route_ctrl: directed scenarios plus random traffic against a
// timestamp-based reference model of the trigger rules.
module tb_trig_route_ctrl;
  localparam int NSRC = 3;
  localparam int SELW = 2;
  localparam int TW   = 16;
  localparam int CW   = 4;
  localparam int HBW  = 4;
  localparam int CMAX = (1 << CW) - 1;
`ifdef TRIG_ROUTE_GLITCH_FILTER_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif
  localparam int PW = LAT - 1;

  logic ext_clock = 1'b0;
  logic resetn    = 1'b1;
  always #5 ext_clock = ~ext_clock;

  trig_route_ctrl_if #(.pNUM_SRC(NSRC), .pSEL_WIDTH(SELW), .pTIME_WIDTH(TW), .pCNT_WIDTH(CW)) ifc ();

  trig_route_ctrl #(.pNUM_SRC(NSRC), .pSEL_WIDTH(SELW), .pTIME_WIDTH(TW),
                    .pCNT_WIDTH(CW), .pHB_WIDTH(HBW)) dut (
    .ext_clock(ext_clock),
    .resetn   (resetn),
    .bus      (ifc)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: edge index plus timestamps of when the pulse and busy windows end
  int cyc, trig_end, busy_end, free_at, e_cnt, hb_cnt;
  bit f1, f2, s_prev, e_trig, e_drop, e_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc = 0; trig_end = 0; busy_end = 0; free_at = 0; e_cnt = 0; hb_cnt = 0;
    f1 = 0; f2 = 0; s_prev = 0; e_trig = 0; e_drop = 0; e_busy = 0;
  endtask

  task automatic model_edge();
    bit s_now, det, idle, f_now, trig_before;
    int w;
    trig_before = e_trig;
    s_now = 1'b0;
    if (int'(ifc.I_src_sel) < NSRC) s_now = ifc.I_trig_src[ifc.I_src_sel];
    det  = f1 && !f2;
    idle = (cyc >= free_at);
    if (idle) begin
      if (!ifc.I_mode) begin
        e_trig = f1;
        if (det && e_cnt < CMAX) e_cnt++;
      end else if (det) begin
        w = (ifc.I_min_width == 0) ? 1 : int'(ifc.I_min_width);
        trig_end = cyc + w;
        busy_end = cyc + w + int'(ifc.I_holdoff);
        free_at  = busy_end + 1;
        e_trig   = 1'b1;
        if (e_cnt < CMAX) e_cnt++;
      end else begin
        e_trig = 1'b0;
      end
    end else begin
      e_trig = (cyc < trig_end);
      if (det) e_drop = 1'b1;
    end
    e_busy = (cyc < busy_end);
    if (ifc.I_count_clr) begin
      e_cnt  = 0;
      e_drop = 1'b0;
    end
    if (!trig_before) hb_cnt = (hb_cnt + 1) % (1 << HBW);
`ifdef TRIG_ROUTE_GLITCH_FILTER_EN
    if (s_prev && s_now)        f_now = 1'b1;
    else if (!s_prev && !s_now) f_now = 1'b0;
    else                        f_now = f1;
`else
    f_now = s_now;
`endif
    f2 = f1; f1 = f_now; s_prev = s_now;
    cyc++;
  endtask

  task automatic step();
    @(posedge ext_clock);
    model_edge();
    #1;
    chk("trig_out", ifc.O_trig_out, e_trig);
    chk("event_count", ifc.O_event_count, e_cnt);
    chk("dropped", ifc.O_dropped, e_drop);
    chk("busy", ifc.O_busy, e_busy);
    chk("heartbeat", ifc.O_heartbeat, hb_cnt >= (1 << (HBW - 1)));
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    #1;
    chk("rst_trig_out", ifc.O_trig_out, 0);
    chk("rst_event_count", ifc.O_event_count, 0);
    chk("rst_dropped", ifc.O_dropped, 0);
    chk("rst_busy", ifc.O_busy, 0);
    chk("rst_heartbeat", ifc.O_heartbeat, 0);
    @(posedge ext_clock);
    @(posedge ext_clock);
    #1;
    resetn = 1'b1;
    model_reset();
  endtask

  task automatic set_cfg(input bit mode, input int w, input int h, input int sel);
    ifc.I_mode      = mode;
    ifc.I_min_width = TW'(w);
    ifc.I_holdoff   = TW'(h);
    ifc.I_src_sel   = SELW'(sel);
  endtask

  task automatic clear_counts();
    ifc.I_count_clr = 1'b1;
    step();
    ifc.I_count_clr = 1'b0;
  endtask

  initial begin
    int hi, bz, k;
    logic hb0;
    ifc.I_trig_src = '0;
    ifc.I_count_clr = 1'b0;
    set_cfg(1'b0, 0, 0, 0);
    model_reset();
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) step();

    // Level mode, 5-cycle pulse on source 1
    set_cfg(1'b0, 0, 0, 1);
    hi = 0;
    for (int i = 0; i < 12; i++) begin
      ifc.I_trig_src = (i < 5) ? 3'b010 : 3'b000;
      step();
      if (ifc.O_trig_out === 1'b1) hi++;
    end
    chk("level_high_cycles", hi, 5);
    chk("level_count", ifc.O_event_count, 1);

    // A single-cycle source pulse: triggers unless the glitch filter is built in
    ifc.I_trig_src = 3'b010; step();
    ifc.I_trig_src = 3'b000;
    for (int i = 0; i < 5; i++) step();

    // Pulse mode W=3 H=4, source 2 held high
    clear_counts();
    set_cfg(1'b1, 3, 4, 2);
    hi = 0; bz = 0;
    for (int i = 0; i < 24; i++) begin
      ifc.I_trig_src = (i < 20) ? 3'b100 : 3'b000;
      step();
      if (ifc.O_trig_out === 1'b1) hi++;
      if (ifc.O_busy === 1'b1) bz++;
    end
    chk("pulse_high_cycles", hi, 3);
    chk("pulse_busy_cycles", bz, 7);
    chk("pulse_count", ifc.O_event_count, 1);
    chk("pulse_dropped", ifc.O_dropped, 0);

    // Retrigger: edges at 0 (accepted), 5 (dropped), 9 (accepted)
    clear_counts();
    for (int i = 0; i < 30; i++) begin
      ifc.I_trig_src = (i == 0 || i == 1 || i == 5 || i == 6 || i == 9 || i == 10) ? 3'b100 : 3'b000;
      step();
    end
    chk("retrig_count", ifc.O_event_count, 2);
    chk("retrig_dropped", ifc.O_dropped, 1);

    // W=0 H=0 back-to-back edges, counter saturation
    clear_counts();
    set_cfg(1'b1, 0, 0, 2);
    for (int p = 0; p < 20; p++) begin
      for (int i = 0; i < 2 * PW; i++) begin
        ifc.I_trig_src = (i < PW) ? 3'b100 : 3'b000;
        step();
      end
    end
    for (int i = 0; i < 4; i++) step();
    chk("sat_count", ifc.O_event_count, CMAX);
    chk("sat_dropped", ifc.O_dropped, 0);

    // Clear on the same edge as an accepted trigger
    hi = 0;
    for (int i = 0; i < 10; i++) begin
      ifc.I_trig_src  = (i < PW) ? 3'b100 : 3'b000;
      ifc.I_count_clr = (i == LAT - 1);
      step();
      if (ifc.O_trig_out === 1'b1) hi++;
    end
    ifc.I_count_clr = 1'b0;
    chk("clr_edge_count", ifc.O_event_count, 0);
    chk("clr_edge_pulse", hi, 1);

    // Heartbeat half-period with trigger idle
    k = 0;
    hb0 = ifc.O_heartbeat;
    while (ifc.O_heartbeat === hb0 && k < 20) begin step(); k++; end
    chk("hb_toggle_seen", (k < 20), 1);
    k = 0;
    hb0 = ifc.O_heartbeat;
    while (ifc.O_heartbeat === hb0 && k < 20) begin step(); k++; end
    chk("hb_half_period", k, 8);

    // Out-of-range select reads as zero
    set_cfg(1'b0, 0, 0, 3);
    hi = 0;
    for (int i = 0; i < 8; i++) begin
      ifc.I_trig_src = 3'b111;
      step();
      if (ifc.O_trig_out === 1'b1) hi++;
    end
    chk("sel_oob_high_cycles", hi, 0);
    ifc.I_trig_src = '0;
    for (int i = 0; i < 3; i++) step();

    // Long pulse freezes heartbeat; reset aborts it mid-pulse
    set_cfg(1'b1, 10, 2, 0);
    ifc.I_trig_src = 3'b001;
    for (int i = 0; i < 7; i++) step();
    chk("midpulse_trig_high", ifc.O_trig_out, 1);
    do_reset();
    ifc.I_trig_src = '0;
    for (int i = 0; i < 3; i++) step();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      if (i % 40 == 0)
        set_cfg(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                int'($urandom_range(0, 5)), int'($urandom_range(0, 3)));
      else if ($urandom_range(0, 15) == 0)
        ifc.I_src_sel = SELW'($urandom_range(0, 3));
      ifc.I_trig_src  = NSRC'($urandom);
      ifc.I_count_clr = ($urandom_range(0, 30) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule

// File: doc/trig_route_ctrl.md
# trig_route_ctrl

Parametrised trigger router and conditioner for the CW305 DesignStart top level. It generalises the fixed two-way soft/trace trigger select and the free-running LED heartbeat into one block. The block selects one of pNUM_SRC trigger sources and either passes it through as a level or shapes it into a pulse with a guaranteed width and a holdoff window. It also counts accepted triggers, flags triggers dropped during busy periods, and provides a heartbeat that freezes while the trigger is asserted. It sits between the M3 GPIO trigger, trace-matcher trigger and other sources, and drives the board trig_out pin.

## Interface
- pNUM_SRC, 4: number of trigger sources, minimum 2.
- pSEL_WIDTH, $clog2(pNUM_SRC): width of the source select.
- pTIME_WIDTH, 16: width of the width and holdoff fields.
- pCNT_WIDTH, 16: width of the event counter.
- pHB_WIDTH, 23: width of the heartbeat counter.

Ports (name, direction, width, meaning):
- ext_clock, in, 1: block clock.
- resetn, in, 1: reset, asynchronous, active-low.
- I_trig_src, in, pNUM_SRC: trigger sources, already synchronous to ext_clock.
- I_src_sel, in, pSEL_WIDTH: selected source index. An index ≥ pNUM_SRC selects constant 0.
- I_mode, in, 1: 0 = level passthrough, 1 = pulse mode.
- I_min_width, in, pTIME_WIDTH: pulse-mode output width in cycles. 0 is treated as 1.
- I_holdoff, in, pTIME_WIDTH: cycles after a pulse during which new edges are ignored.
- I_count_clr, in, 1: synchronous clear of O_event_count and O_dropped.
- O_trig_out, out, 1: conditioned trigger, registered.
- O_event_count, out, pCNT_WIDTH: accepted rising edges, saturating.
- O_dropped, out, 1: sticky flag; an edge arrived while not IDLE.
- O_busy, out, 1: high when the FSM is in ACTIVE or HOLDOFF.
- O_heartbeat, out, 1: MSB of the heartbeat counter.

## Operation
- Input pipeline:
  - sel_q <= I_trig_src[I_src_sel]; sel_d <= sel_q.
  - edge = sel_q & ~sel_d.
  - Changing I_src_sel can produce an edge. This is legal; the edge is processed normally.
- Level mode (I_mode=0, sampled in IDLE):
  - FSM stays in IDLE.
  - O_trig_out <= sel_q.
  - Each edge increments the counter.
  - O_busy = 0 and O_dropped is never set.
- Pulse-mode FSM (I_mode=1):
  - IDLE, on edge: go to ACTIVE; O_trig_out <= 1; tcnt <= max(I_min_width,1); increment the counter.
  - ACTIVE: tcnt decrements each cycle. At tcnt==1: O_trig_out <= 0, then go to HOLDOFF with tcnt <= I_holdoff if I_holdoff≠0, otherwise go to IDLE.
  - HOLDOFF: tcnt decrements. At tcnt==1, go to IDLE.
  - An edge in ACTIVE or HOLDOFF is not counted and sets O_dropped.
- I_mode, I_min_width and I_holdoff are sampled only when leaving IDLE. Changes mid-pulse take effect on the next trigger.
- Event counter: saturates at all-ones and never wraps. I_count_clr wins over a same-cycle increment.
- Heartbeat: the pHB_WIDTH counter increments every cycle while O_trig_out==0 and holds while it is 1. It wraps at all-ones.

## Timing
- On reset, all outputs, counters and pipeline flops are 0 and the FSM is in IDLE. Reset asynchronously aborts a pulse mid-operation.
- Source to O_trig_out latency is 2 ext_clock edges in both modes.
- Pulse mode:
  - O_trig_out is high for exactly max(W,1) cycles.
  - Edges are accepted again H cycles after O_trig_out falls.
  - The minimum retrigger period is max(W,1)+H+1 cycles, including one IDLE cycle.
- O_event_count updates in the same cycle O_trig_out rises.
- O_dropped sets one cycle after the offending edge is detected.

## Configuration
- TRIG_ROUTE_GLITCH_FILTER_EN defined:
  - sel_q only rises after the selected source has been high for 2 consecutive cycles.
  - sel_q only falls after the source has been low for 2 consecutive cycles.
  - Source to output latency becomes 3 edges.
  - Single-cycle pulses are ignored.
- Not defined: no filter, 2-edge latency, and single-cycle pulses trigger normally.

## Test plan
- Level mode, sel=1, 5-cycle pulse on src[1] -> O_trig_out high for 5 cycles starting 2 edges later; count=1; busy=0.
- Pulse mode, W=3, H=4, src[2] held high 20 cycles -> one 3-cycle pulse; count=1; dropped=0; busy high for 7 cycles.
- Pulse mode, W=3, H=4, second edge 5 cycles after the first -> no second pulse; dropped=1; count=1. An edge at cycle 9 is accepted; count=2.
- Pulse mode, W=0, H=0, edges every 2 cycles -> each produces a 1-cycle pulse; count increments each time. Count preset near 0xFFFF saturates at 0xFFFF. Count_clr together with an edge -> count=0.
- Heartbeat with pHB_WIDTH=4 -> O_heartbeat toggles every 8 cycles and freezes while O_trig_out=1. resetn low mid-pulse -> all outputs 0 immediately.
- With TRIG_ROUTE_GLITCH_FILTER_EN, a 1-cycle src pulse -> no trigger. A 2-cycle pulse -> trigger 3 edges after the rising edge.
